pio_multi: RTL
==============

PIO_MULTI -- requirements
Module: pio_multi

Interface
REQ-001 Parameter WIDTH, default 4: number of input and output channels, legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: capture mode; 0 = rising, 1 = falling, 2 = any edge.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: stability window in clocks, legal range 1..65535.
REQ-004 Parameter OUT_RESET, default 0: reset value of out_port.
REQ-005 clk_clk  in  1  sole clock; all logic is rising-edge.
REQ-006 reset_reset  in  1  synchronous, active-high reset.
REQ-007 s0_address  in  3  word address.
REQ-008 s0_read  in  1  read strobe.
REQ-009 s0_write  in  1  write strobe.
REQ-010 s0_writedata  in  32  write data.
REQ-011 s0_readdata  out  32  read data.
REQ-012 s0_readdatavalid  out  1  read data qualifier.
REQ-013 s0_waitrequest  out  1  tied 0; every access is accepted in the cycle it is presented.
REQ-014 in_port  in  WIDTH  asynchronous external inputs.
REQ-015 out_port  out  WIDTH  registered outputs.
REQ-016 irq  out  1  level interrupt.

Function
REQ-017 Register map (word address, access): 0 DATA (read = debounced inputs, write = out_port); 1 IRQ_MASK (RW); 2 EDGE_CAPTURE (R, write-1-to-clear); 3 OUTSET (W1S out_port); 4 OUTCLEAR (W1C out_port); 5 OUT_RB (R, out_port).
REQ-018 Bits [31:WIDTH] read as 0 and ignore writes; reads of addresses 6-7 return 0; writes to read-only addresses have no effect.
REQ-019 Read latency is exactly 1 clock: s0_readdatavalid is high for one cycle, the cycle after s0_read is sampled high.
REQ-020 Simultaneous s0_read and s0_write: both are performed; the read returns the pre-write value.
REQ-021 Each in_port bit passes through a 2-flop synchroniser (s1, s2).
REQ-022 Debounced value d[i] takes s2[i] only after s2[i] has differed from d[i] for DEBOUNCE_CYCLES consecutive clocks.
REQ-023 A shorter disagreement reloads that bit's counter, leaving d[i] unchanged.
REQ-024 Edge detect compares d with its 1-cycle-delayed copy d_q; a qualifying edge per EDGE_TYPE sets EDGE_CAPTURE[i] on the next clock.
REQ-025 Same-cycle edge set and W1C clear on one bit: set wins.
REQ-026 irq = OR of (EDGE_CAPTURE & IRQ_MASK), driven only from flops; irq deasserts the cycle after the clearing write or mask write.
REQ-027 OUTSET and OUTCLEAR take effect on the clock that samples the write; out_port updates the following cycle.
REQ-028 An input held at 1 through reset yields a rising-edge capture after reset; software clears EDGE_CAPTURE during init.

Reset
REQ-029 Reset values: out_port = OUT_RESET; IRQ_MASK, EDGE_CAPTURE, s1, s2, d, d_q and all counters = 0; s0_readdata = 0; s0_readdatavalid = 0; irq = 0.
REQ-030 Reset asserted mid-read suppresses the pending s0_readdatavalid.

Configuration
REQ-031 Macro PIO_MULTI_DEBOUNCE_EN defined: debounce counters per REQ-022/023 are present.
REQ-032 PIO_MULTI_DEBOUNCE_EN undefined: no counters are built and d = s2 directly; DEBOUNCE_CYCLES is ignored.

Verification
REQ-033 WIDTH=4, EDGE_TYPE=0, debounce off: in_port 0->1 on bit 2 at cycle 0, mask=4 -> EDGE_CAPTURE=0x4 and irq=1 at cycle 3; write 0x4 to address 2 -> irq=0 the next cycle.
REQ-034 Debounce on, DEBOUNCE_CYCLES=4: 3-cycle pulse on bit 0 -> no DATA change, no capture; 10-cycle high -> DATA bit 0 = 1 and one capture.
REQ-035 EDGE_TYPE=2: toggle bit 1 twice with W1C between -> capture set twice; W1C issued in the same cycle as the second edge -> bit remains 1.
REQ-036 OUT_RESET=0x5: after reset out_port=0x5; OUTSET 0x2 -> 0x7; OUTCLEAR 0x1 -> 0x6; read address 5 -> 0x6 with readdatavalid one cycle after read.
REQ-037 Read address 2 while a write of 0xF to address 2 is in the same cycle -> returns the pre-clear value; reset asserted the cycle after a read -> readdatavalid stays 0.

Source files
------------

// File: rtl/pio_multi.sv
// pio_multi: multi-channel parallel I/O with a memory-mapped slave port.
// Provides 2-flop input synchronisers, optional per-bit debounce, edge capture with
// maskable level interrupt, and a registered output port with set/clear aliases.
// Optional feature macro: PIO_MULTI_DEBOUNCE_EN (builds per-bit debounce counters;
// when undefined the debounced value is the synchroniser output and DEBOUNCE_CYCLES
// is unused).
module pio_multi #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic [31:0] OUT_RESET       = 32'h0
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [2:0]       s0_address,
   input  logic             s0_read,
   input  logic             s0_write,
   input  logic [31:0]      s0_writedata,
   output logic [31:0]      s0_readdata,
   output logic             s0_readdatavalid,
   output logic             s0_waitrequest,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [2:0] AddrData   = 3'd0;
   localparam logic [2:0] AddrMask   = 3'd1;
   localparam logic [2:0] AddrCap    = 3'd2;
   localparam logic [2:0] AddrOutSet = 3'd3;
   localparam logic [2:0] AddrOutClr = 3'd4;
   localparam logic [2:0] AddrOutRb  = 3'd5;

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_dly_q;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] wdata_w;
   logic [31:0]      rdata_q, rdata_d;
   logic             rvalid_q;

   assign wdata_w = s0_writedata[WIDTH-1:0];

`ifdef PIO_MULTI_DEBOUNCE_EN
   localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

   logic [15:0]      cnt_q [WIDTH];
   logic [WIDTH-1:0] deb_q;

   // Per-bit stability counter: adopt s2 only after DEBOUNCE_CYCLES straight disagreements.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         deb_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] != deb_q[i]) begin
               if (cnt_q[i] == CntLast) begin
                  deb_q[i] <= s2_q[i];
                  cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 16'd1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign deb = deb_q;
`else
   assign deb = s2_q;
`endif

   // Edge qualification of the debounced value against its one-cycle-old copy.
   always_comb begin
      edge_hit = '0;
      if (EDGE_TYPE == 0) begin
         edge_hit = deb & ~deb_dly_q;
      end else if (EDGE_TYPE == 1) begin
         edge_hit = ~deb & deb_dly_q;
      end else begin
         edge_hit = deb ^ deb_dly_q;
      end
   end

   // Register writes and read mux; reads see pre-write state, edge set beats W1C.
   always_comb begin
      out_d   = out_q;
      mask_d  = mask_q;
      cap_clr = '0;
      rdata_d = '0;
      if (s0_write) begin
         case (s0_address)
            AddrData:   out_d   = wdata_w;
            AddrMask:   mask_d  = wdata_w;
            AddrCap:    cap_clr = wdata_w;
            AddrOutSet: out_d   = out_q | wdata_w;
            AddrOutClr: out_d   = out_q & ~wdata_w;
            default:    ;
         endcase
      end
      cap_d = (cap_q & ~cap_clr) | edge_hit;
      if (s0_read) begin
         case (s0_address)
            AddrData:  rdata_d[WIDTH-1:0] = deb;
            AddrMask:  rdata_d[WIDTH-1:0] = mask_q;
            AddrCap:   rdata_d[WIDTH-1:0] = cap_q;
            AddrOutRb: rdata_d[WIDTH-1:0] = out_q;
            default:   rdata_d = '0;
         endcase
      end
   end

   // State registers: synchronisers, edge history, control registers, read response.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         s1_q      <= '0;
         s2_q      <= '0;
         deb_dly_q <= '0;
         out_q     <= OUT_RESET[WIDTH-1:0];
         mask_q    <= '0;
         cap_q     <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
      end else begin
         s1_q      <= in_port;
         s2_q      <= s1_q;
         deb_dly_q <= deb;
         out_q     <= out_d;
         mask_q    <= mask_d;
         cap_q     <= cap_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= s0_read;
      end
   end

   assign s0_readdata      = rdata_q;
   assign s0_readdatavalid = rvalid_q;
   assign s0_waitrequest   = 1'b0;
   assign out_port         = out_q;
   // Pure function of flops, so no input-to-irq combinational path.
   assign irq              = |(cap_q & mask_q);

endmodule
